// File: rtl/nrzi_line_encoder_if.sv
// nrzi_line_encoder_if: stuffed bitstream in, NRZI line pair and status out
interface nrzi_line_encoder_if;
   logic       bstr_in;
   logic [1:0] bstr_in_ready;
   logic       dp;
   logic       dm;
   logic       oe;
   logic       busy;
   logic       done;
   logic       stuff_err;
   logic       ovr_err;
   modport master (
      output bstr_in, bstr_in_ready,
      input  dp, dm, oe, busy, done, stuff_err, ovr_err
   );
   modport slave (
      input  bstr_in, bstr_in_ready,
      output dp, dm, oe, busy, done, stuff_err, ovr_err
   );
endinterface

// File: rtl/nrzi_line_encoder.sv
// nrzi_line_encoder: NRZI-encodes a stuffed USB bitstream onto D+/D- with EOP framing and stuff/overrun checks
module nrzi_line_encoder #(
   parameter int SE0_CYCLES = 2,
   parameter int J_CYCLES   = 1,
   parameter int MAX_ONES   = 6
) (
   input logic                clk,
   input logic                rst,
   nrzi_line_encoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, XMIT, EOP_SE0, EOP_J} state_t;
   state_t     r_state;
   logic       r_level, r_dp, r_dm, r_oe, r_busy, r_done, r_stuff, r_ovr;
   logic [3:0] r_ones, r_cnt;
   logic       w_data, w_lvl_nxt, w_viol;
   logic [3:0] w_ones_nxt;
   assign w_data     = bus.bstr_in_ready == 2'b01;
   assign w_lvl_nxt  = bus.bstr_in ? r_level : ~r_level;
   // run length saturates one past the limit so a long run keeps flagging without wrapping
   assign w_ones_nxt = !bus.bstr_in ? 4'd0 : r_ones == 4'(MAX_ONES + 1) ? r_ones : r_ones + 4'd1;
   assign w_viol     = bus.bstr_in && w_ones_nxt > 4'(MAX_ONES);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_level <= 1'b1;
         r_ones  <= 4'd0;
         r_cnt   <= 4'd0;
         r_dp    <= 1'b1;
         r_dm    <= 1'b0;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_stuff <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_ovr  <= 1'b0;
         case (r_state)
            IDLE: if (w_data) begin
               r_state <= XMIT;
               r_level <= w_lvl_nxt;
               r_dp    <= w_lvl_nxt;
               r_dm    <= ~w_lvl_nxt;
               r_oe    <= 1'b1;
               r_busy  <= 1'b1;
               r_ones  <= w_ones_nxt;
               r_stuff <= w_viol;
            end
            XMIT: if (w_data) begin
               r_level <= w_lvl_nxt;
               r_dp    <= w_lvl_nxt;
               r_dm    <= ~w_lvl_nxt;
               r_ones  <= w_ones_nxt;
               r_stuff <= r_stuff | w_viol;
            end else begin
               r_state <= EOP_SE0;
               r_dp    <= 1'b0;
               r_dm    <= 1'b0;
               r_cnt   <= 4'(SE0_CYCLES - 1);
            end
            EOP_SE0: begin
               r_ovr <= w_data;
               if (r_cnt == 4'd0) begin
                  r_state <= EOP_J;
                  r_dp    <= 1'b1;
                  r_dm    <= 1'b0;
                  r_cnt   <= 4'(J_CYCLES - 1);
               end else r_cnt <= r_cnt - 4'd1;
            end
            EOP_J: begin
               r_ovr <= w_data;
               if (r_cnt == 4'd0) begin
                  r_state <= IDLE;
                  r_oe    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_level <= 1'b1;
                  r_ones  <= 4'd0;
               end else r_cnt <= r_cnt - 4'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.dp        = r_dp;
   assign bus.dm        = r_dm;
   assign bus.oe        = r_oe;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.stuff_err = r_stuff;
   assign bus.ovr_err   = r_ovr;
endmodule

// File: tb/tb_nrzi_line_encoder.sv
// tb_nrzi_line_encoder: directed vectors with queued expectations checked by an independent monitor
module tb_nrzi_line_encoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [6:0] q_exp[$];
   string      q_name[$];
   // vector order: {dp, dm, oe, busy, done, stuff_err, ovr_err}
   localparam logic [6:0] RST = 7'b1000000;
   localparam logic [6:0] KX  = 7'b0111000;
   localparam logic [6:0] JX  = 7'b1011000;
   localparam logic [6:0] SE0 = 7'b0011000;
   localparam logic [6:0] DN  = 7'b1000100;
   localparam logic [6:0] ST  = 7'b0000010;
   localparam logic [6:0] OV  = 7'b0000001;
   nrzi_line_encoder_if bus ();
   nrzi_line_encoder dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic step(input logic r, input logic [1:0] rdy, input logic b, input logic [6:0] exp, input string nm);
      @(negedge clk);
      rst = r;
      bus.bstr_in_ready = rdy;
      bus.bstr_in = b;
      q_exp.push_back(exp);
      q_name.push_back(nm);
   endtask
   initial begin : monitor
      logic [6:0] got, exp;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() > 0) begin
            exp = q_exp.pop_front();
            nm  = q_name.pop_front();
            got = {bus.dp, bus.dm, bus.oe, bus.busy, bus.done, bus.stuff_err, bus.ovr_err};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL %s got %b expected %b", nm, got, exp);
            end
         end
      end
   end
   initial begin : stim
      bus.bstr_in = 1'b0;
      bus.bstr_in_ready = 2'b00;
      step(1, 2'b00, 0, RST, "reset");
      step(0, 2'b00, 0, RST, "idle_00");
      step(0, 2'b11, 1, RST, "idle_11");
      step(0, 2'b10, 0, RST, "idle_10");
      step(0, 2'b01, 0, KX, "sync0");
      step(0, 2'b01, 0, JX, "sync1");
      step(0, 2'b01, 0, KX, "sync2");
      step(0, 2'b01, 0, JX, "sync3");
      step(0, 2'b01, 0, KX, "sync4");
      step(0, 2'b01, 0, JX, "sync5");
      step(0, 2'b01, 0, KX, "sync6");
      step(0, 2'b01, 1, KX, "sync7");
      step(0, 2'b00, 0, SE0, "eop1_se0a");
      step(0, 2'b00, 0, SE0, "eop1_se0b");
      step(0, 2'b00, 0, JX, "eop1_j");
      step(0, 2'b00, 0, DN, "eop1_done");
      step(0, 2'b00, 0, RST, "idle_after1");
      for (int i = 0; i < 6; i++) step(0, 2'b01, 1, JX, $sformatf("six_ones%0d", i));
      step(0, 2'b01, 0, KX, "six_zero");
      step(0, 2'b01, 1, KX, "six_last1");
      step(0, 2'b10, 0, SE0, "eop2_se0a");
      step(0, 2'b00, 0, SE0, "eop2_se0b");
      step(0, 2'b00, 0, JX, "eop2_j");
      step(0, 2'b00, 0, DN, "eop2_done");
      for (int i = 0; i < 6; i++) step(0, 2'b01, 1, JX, $sformatf("b2b_one%0d", i));
      step(0, 2'b01, 1, JX | ST, "seventh_one");
      step(0, 2'b00, 0, SE0 | ST, "eop3_se0a");
      step(0, 2'b01, 0, SE0 | ST | OV, "eop3_ovr");
      step(0, 2'b00, 0, JX | ST, "eop3_j");
      step(0, 2'b00, 0, DN | ST, "eop3_done");
      step(0, 2'b00, 0, RST | ST, "stuff_sticky_a");
      step(0, 2'b00, 0, RST | ST, "stuff_sticky_b");
      step(0, 2'b01, 0, KX, "stuff_clear");
      step(0, 2'b01, 1, KX, "lvl0_hold");
      step(1, 2'b01, 0, RST, "mid_reset");
      step(0, 2'b01, 0, KX, "post_rst0");
      step(0, 2'b01, 0, JX, "post_rst1");
      step(0, 2'b00, 0, SE0, "eop4_se0a");
      step(0, 2'b00, 0, SE0, "eop4_se0b");
      step(0, 2'b00, 0, JX, "eop4_j");
      step(0, 2'b00, 0, DN, "eop4_done");
      step(0, 2'b00, 0, RST, "idle_final");
      for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
      #2;
      if (q_exp.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", q_exp.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
